// File: rtl/enc_chan_sched.sv
// Purpose: time-division scheduler that runs the shared ADPCM encoder once per enabled channel on each frame strobe.
// Latency: the frame starts one cycle after fs; a channel costs 5+d cycles if enabled, 2 if disabled, and 3+TIMEOUT if it times out.
// Backpressure: none; an fs that arrives while busy is dropped and latched into the sticky overrun flag.
module enc_chan_sched #(
   parameter int NCH     = 32,
   parameter int CW      = 5,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           fs,
   input  logic [NCH-1:0] ch_mask,
   input  logic           enc_done,
   input  logic           err_clr,
   output logic [CW-1:0]  ch_sel,
   output logic           state_rd,
   output logic           enc_start,
   output logic           state_wr,
   output logic           busy,
   output logic           frame_done,
   output logic           overrun,
   output logic           timeout_err
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      STORE = 3'd4,
      NEXT  = 3'd5
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [NCH-1:0] mask_q;
   logic [TW-1:0]  timer;
   logic           last_ch;
   logic           tmo_hit;

   assign last_ch = (ch_sel == CW'(NCH - 1));
   assign tmo_hit = (timer == TW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and strobe decode; strobes depend only on registered state
   always_comb begin
      state_nxt  = state;
      state_rd   = 1'b0;
      enc_start  = 1'b0;
      state_wr   = 1'b0;
      frame_done = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (fs) state_nxt = LOAD;
         end
         LOAD: begin
            if (mask_q[ch_sel]) begin
               state_rd  = 1'b1;
               state_nxt = START;
            end else begin
               state_nxt = NEXT;
            end
         end
         START: begin
            enc_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (enc_done)     state_nxt = STORE;
            else if (tmo_hit) state_nxt = NEXT;   // abandon pass, RAM untouched
         end
         STORE: begin
            state_wr  = 1'b1;
            state_nxt = NEXT;
         end
         NEXT: begin
            if (last_ch) begin
               frame_done = 1'b1;
               state_nxt  = IDLE;
            end else begin
               state_nxt  = LOAD;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Channel index, latched mask, WAIT timer and sticky error flags (set beats clear)
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q      <= '0;
         ch_sel      <= '0;
         timer       <= '0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE && fs) begin
            mask_q <= ch_mask;
            ch_sel <= '0;
         end else if (state == NEXT && !last_ch) begin
            ch_sel <= ch_sel + 1'b1;
         end

         if (state == START)
            timer <= '0;
         else if (state == WAIT && !enc_done && !tmo_hit)
            timer <= timer + 1'b1;

         overrun     <= (fs && state != IDLE) | (overrun & ~err_clr);
         timeout_err <= (state == WAIT && !enc_done && tmo_hit) | (timeout_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_enc_chan_sched.sv
// Purpose: scoreboard bench for enc_chan_sched with a behavioural encoder responding to enc_start.
// Latency: expected strobe cycles are computed from per-channel cycle costs relative to the accepted fs.
// Backpressure: n/a; the encoder model either answers after d WAIT cycles or hangs on selected channels.
module tb_enc_chan_sched;

   localparam int NCH     = 4;
   localparam int CW      = 2;
   localparam int TIMEOUT = 8;

   localparam int K_RD   = 0;
   localparam int K_ST   = 1;
   localparam int K_WR   = 2;
   localparam int K_DONE = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic           fs;
   logic [NCH-1:0] ch_mask;
   logic           enc_done;
   logic           err_clr;
   logic [CW-1:0]  ch_sel;
   logic           state_rd;
   logic           enc_start;
   logic           state_wr;
   logic           busy;
   logic           frame_done;
   logic           overrun;
   logic           timeout_err;

   typedef struct {
      int kind;
      int ch;
      int cyc;
   } ev_t;

   ev_t            exp_q[$];
   int             vectors     = 0;
   int             miscompares = 0;
   int             tcyc        = 0;
   int             f0          = 0;
   int             wr_cnt      = 0;
   int             enc_d       = 1;
   int             enc_cnt     = 0;
   logic [NCH-1:0] hang_mask   = '0;

   always #5 clk = ~clk;

   // Free-running cycle count used to time-stamp DUT events
   always @(posedge clk) tcyc <= tcyc + 1;

   enc_chan_sched #(.NCH(NCH), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .fs          (fs),
      .ch_mask     (ch_mask),
      .enc_done    (enc_done),
      .err_clr     (err_clr),
      .ch_sel      (ch_sel),
      .state_rd    (state_rd),
      .enc_start   (enc_start),
      .state_wr    (state_wr),
      .busy        (busy),
      .frame_done  (frame_done),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   // Encoder model: enc_done d+1 cycles after enc_start (d WAIT cycles), never for hung channels
   initial begin
      enc_done = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            enc_cnt  = 0;
            enc_done = 1'b0;
         end else begin
            enc_done = 1'b0;
            if (enc_cnt > 0) begin
               enc_cnt = enc_cnt - 1;
               if (enc_cnt == 0) enc_done = 1'b1;
            end
            if (enc_start && !hang_mask[ch_sel]) enc_cnt = enc_d + 1;
         end
      end
   end

   // Scoreboard: every strobe pops the next expected event and is compared on kind, channel and cycle
   initial begin
      logic [3:0] strb;
      ev_t        e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            strb = {frame_done, state_wr, enc_start, state_rd};
            for (int k = 0; k < 4; k++) begin
               if (strb[k]) begin
                  vectors++;
                  if (k == K_WR) wr_cnt++;
                  if (exp_q.size() == 0) begin
                     miscompares++;
                     $display("FAIL sched_event: got kind=%0d ch=%0d cyc=%0d, expected no event", k, ch_sel, tcyc - f0);
                  end else begin
                     e = exp_q.pop_front();
                     if (e.kind !== k || e.ch !== int'(ch_sel) || e.cyc !== (tcyc - f0)) begin
                        miscompares++;
                        $display("FAIL sched_event: got kind=%0d ch=%0d cyc=%0d, expected kind=%0d ch=%0d cyc=%0d",
                                 k, ch_sel, tcyc - f0, e.kind, e.ch, e.cyc);
                     end
                  end
               end
            end
         end
      end
   end

   task automatic push_ev(input int kind, input int ch, input int cyc, input int cut);
      ev_t e;
      e.kind = kind;
      e.ch   = ch;
      e.cyc  = cyc;
      if (cyc < cut) exp_q.push_back(e);
   endtask

   // Expected schedule from per-channel costs; events at or after 'cut' are not expected
   task automatic push_frame(input logic [NCH-1:0] m, input int d, input logic [NCH-1:0] h, input int cut);
      int c;
      c = 1;
      for (int ch = 0; ch < NCH; ch++) begin
         if (m[ch]) begin
            push_ev(K_RD, ch, c, cut);
            push_ev(K_ST, ch, c + 1, cut);
            if (h[ch]) begin
               c = c + 3 + TIMEOUT;
            end else begin
               push_ev(K_WR, ch, c + 3 + d, cut);
               c = c + 5 + d;
            end
         end else begin
            c = c + 2;
         end
      end
      push_ev(K_DONE, NCH - 1, c - 1, cut);
   endtask

   // Called at a negedge; drives fs for cycle 0 and returns at the negedge of cycle 1
   task automatic start_frame(input logic [NCH-1:0] m, input int d, input logic [NCH-1:0] h, input int cut);
      enc_d     = d;
      hang_mask = h;
      ch_mask   = m;
      fs        = 1'b1;
      f0        = tcyc;
      push_frame(m, d, h, cut);
      @(negedge clk);
      fs = 1'b0;
   endtask

   task automatic wait_frame(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (frame_done) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if ({state_rd, enc_start, state_wr, frame_done} !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_strobes: got %b, expected 0000", {state_rd, enc_start, state_wr, frame_done});
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy: got %b, expected 0", busy);
      end
      vectors++;
      if (ch_sel !== '0) begin
         miscompares++;
         $display("FAIL reset_ch_sel: got %0d, expected 0", ch_sel);
      end
      vectors++;
      if ({overrun, timeout_err} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_flags: got %b, expected 00", {overrun, timeout_err});
      end
   endtask

   task automatic test_full_frame();
      bit seen;
      wr_cnt = 0;
      start_frame(4'b1111, 1, 4'b0000, 1000);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL full_busy_rise: got %b, expected 1", busy);
      end
      wait_frame(100, seen);
      vectors++;
      if (!seen || (tcyc - f0) != 24) begin
         miscompares++;
         $display("FAIL full_frame_done: got seen=%0b cyc=%0d, expected seen=1 cyc=24", seen, tcyc - f0);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL full_busy_fall: got %b, expected 0", busy);
      end
      vectors++;
      if (wr_cnt != 4 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL full_writes: got wr=%0d left=%0d, expected wr=4 left=0", wr_cnt, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_masked();
      bit seen;
      wr_cnt = 0;
      start_frame(4'b0101, 1, 4'b0000, 1000);
      wait_frame(100, seen);
      vectors++;
      if (!seen || (tcyc - f0) != 16) begin
         miscompares++;
         $display("FAIL masked_frame_done: got seen=%0b cyc=%0d, expected seen=1 cyc=16", seen, tcyc - f0);
      end
      @(negedge clk);
      vectors++;
      if (wr_cnt != 2 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL masked_writes: got wr=%0d left=%0d, expected wr=2 left=0", wr_cnt, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_timeout();
      bit seen;
      wr_cnt = 0;
      start_frame(4'b1111, 1, 4'b0010, 1000);
      wait_frame(200, seen);
      vectors++;
      if (!seen || (tcyc - f0) != 29) begin
         miscompares++;
         $display("FAIL tmo_frame_done: got seen=%0b cyc=%0d, expected seen=1 cyc=29", seen, tcyc - f0);
      end
      vectors++;
      if (timeout_err !== 1'b1) begin
         miscompares++;
         $display("FAIL tmo_flag_set: got %b, expected 1", timeout_err);
      end
      @(negedge clk);
      vectors++;
      if (wr_cnt != 3 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL tmo_writes: got wr=%0d left=%0d, expected wr=3 left=0", wr_cnt, exp_q.size());
      end
      exp_q.delete();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      vectors++;
      if (timeout_err !== 1'b0) begin
         miscompares++;
         $display("FAIL tmo_flag_clr: got %b, expected 0", timeout_err);
      end
   endtask

   task automatic test_overrun();
      bit seen;
      wr_cnt = 0;
      start_frame(4'b1111, 0, 4'b0000, 1000);   // cycle 1; frame_done due at cycle 20
      repeat (4) @(negedge clk);                  // cycle 5
      fs = 1'b1;
      @(negedge clk);                             // cycle 6
      fs = 1'b0;
      vectors++;
      if (overrun !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_busy_set: got %b, expected 1", overrun);
      end
      err_clr = 1'b1;
      @(negedge clk);                             // cycle 7
      vectors++;
      if (overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL ovr_clr: got %b, expected 0", overrun);
      end
      fs = 1'b1;                                  // set and clear together
      @(negedge clk);                             // cycle 8
      fs = 1'b0;
      vectors++;
      if (overrun !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_set_wins: got %b, expected 1", overrun);
      end
      @(negedge clk);                             // cycle 9
      err_clr = 1'b0;
      repeat (11) @(negedge clk);                 // cycle 20
      vectors++;
      if (frame_done !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_done_cycle: got %b, expected 1", frame_done);
      end
      fs = 1'b1;
      @(negedge clk);                             // cycle 21
      fs = 1'b0;
      vectors++;
      if (busy !== 1'b0 || overrun !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_on_done: got busy=%b overrun=%b, expected busy=0 overrun=1", busy, overrun);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || wr_cnt != 4 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL ovr_frame_intact: got busy=%b wr=%0d left=%0d, expected busy=0 wr=4 left=0",
                  busy, wr_cnt, exp_q.size());
      end
      exp_q.delete();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      wr_cnt  = 0;
      start_frame(4'b1111, 1, 4'b0000, 1000);
      wait_frame(100, seen);
      vectors++;
      if (!seen || (tcyc - f0) != 24) begin
         miscompares++;
         $display("FAIL ovr_next_frame: got seen=%0b cyc=%0d, expected seen=1 cyc=24", seen, tcyc - f0);
      end
      @(negedge clk);
      vectors++;
      if (wr_cnt != 4 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL ovr_next_writes: got wr=%0d left=%0d, expected wr=4 left=0", wr_cnt, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_wait();
      bit seen;
      wr_cnt = 0;
      start_frame(4'b1111, 1, 4'b0000, 15);       // only events before cycle 15 expected
      repeat (14) @(negedge clk);                 // cycle 15: first WAIT cycle of ch2
      reset = 1'b1;
      @(negedge clk);                             // cycle 16
      reset = 1'b0;
      vectors++;
      if (busy !== 1'b0 || ch_sel !== '0 ||
          {state_rd, enc_start, state_wr, frame_done} !== 4'b0) begin
         miscompares++;
         $display("FAIL midrst_idle: got busy=%b ch_sel=%0d strobes=%b, expected busy=0 ch_sel=0 strobes=0000",
                  busy, ch_sel, {state_rd, enc_start, state_wr, frame_done});
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (wr_cnt != 2 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL midrst_no_wr: got wr=%0d left=%0d, expected wr=2 left=0", wr_cnt, exp_q.size());
      end
      exp_q.delete();
      wr_cnt = 0;
      start_frame(4'b1111, 1, 4'b0000, 1000);
      wait_frame(100, seen);
      vectors++;
      if (!seen || (tcyc - f0) != 24) begin
         miscompares++;
         $display("FAIL midrst_restart: got seen=%0b cyc=%0d, expected seen=1 cyc=24", seen, tcyc - f0);
      end
      @(negedge clk);
      vectors++;
      if (wr_cnt != 4 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL midrst_writes: got wr=%0d left=%0d, expected wr=4 left=0", wr_cnt, exp_q.size());
      end
      exp_q.delete();
   endtask

   initial begin
      reset   = 1'b1;
      fs      = 1'b0;
      err_clr = 1'b0;
      ch_mask = '0;
      test_reset();
      test_full_frame();
      test_masked();
      test_timeout();
      test_overrun();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/enc_chan_sched.md
# enc_chan_sched

Time-division channel scheduler for the single shared ADPCM encoder (`enc`) in the multi-channel encoder. On every 8 kHz frame strobe it walks through all channels in order. For each enabled channel it:
- loads that channel's predictor state,
- starts one encoder pass and waits for completion,
- writes the updated state back.

It also detects frame overruns and hung encoder passes, and reports both as sticky error flags.

## Interface

Parameters:
- `NCH`, 32: number of channels (≥2).
- `CW`, 5: channel index width, equal to clog2(NCH).
- `TIMEOUT`, 64: maximum WAIT cycles allowed per channel before the pass is abandoned (≥2).

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `fs` in 1: frame strobe, one cycle wide.
- `ch_mask` in NCH: channel enables, sampled on an accepted `fs`.
- `enc_done` in 1: encoder pass complete, one-cycle pulse.
- `err_clr` in 1: clears `overrun` and `timeout_err`.
- `ch_sel` out CW: current channel index; drives the state RAM address and the sample mux.
- `state_rd` out 1: load the channel state into the encoder.
- `enc_start` out 1: start one encoder pass.
- `state_wr` out 1: write the encoder state back to RAM at `ch_sel`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `frame_done` out 1: one-cycle pulse after the last channel is processed.
- `overrun` out 1: sticky; an `fs` arrived while the scheduler was busy.
- `timeout_err` out 1: sticky; some channel's pass timed out.

## Operation

- State machine states: IDLE, LOAD, START, WAIT, STORE, NEXT.
- All outputs are registered or decoded from the state register (Moore). No output depends combinationally on an input.
- **Reset values:** state is IDLE and `ch_sel`=0. All other outputs are 0, the latched mask is cleared, and the timer is 0.
- **IDLE:**
  - If `fs`=1: latch `ch_mask` into `mask_q`, set `ch_sel` to 0, go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD:**
  - If `mask_q[ch_sel]`=1: assert `state_rd` for this cycle and go to START.
  - If `mask_q[ch_sel]`=0: go to NEXT with no strobes.
- **START:** assert `enc_start` for one cycle, clear the timer, go to WAIT.
- **WAIT:**
  - If `enc_done`=1: go to STORE.
  - Else if the timer equals TIMEOUT-1: set `timeout_err`, go to NEXT without entering STORE, so state RAM is left untouched.
  - Else: increment the timer.
- **STORE:** assert `state_wr` for one cycle, go to NEXT.
- **NEXT:**
  - If `ch_sel`=NCH-1: assert `frame_done` for one cycle, go to IDLE.
  - Otherwise increment `ch_sel` and go to LOAD.
- `ch_sel` holds its value from LOAD through NEXT. It never wraps within a frame.
- When no channel is enabled (`ch_mask`=0), the frame still runs LOAD/NEXT for every channel and still produces `frame_done`.
- `fs` is accepted only in IDLE.
  - An `fs` in any other state, including the cycle `frame_done` is high, is dropped and sets `overrun`.
  - That frame is skipped.
- `enc_done` outside WAIT is ignored.
- **Error flags:**
  - `err_clr` clears both sticky flags next cycle.
  - If a set condition and `err_clr` occur in the same cycle, set wins.
- **Reset mid-frame:** returns to IDLE in one cycle, with all strobes low the following cycle. No `state_wr` is issued for the interrupted channel.

## Timing

- `fs` sampled at cycle 0 gives LOAD for ch0 at cycle 1 (`state_rd`) and START at cycle 2 (`enc_start`). WAIT begins at cycle 3.
- If `enc_done` is high at cycle 3+d (d≥0), STORE is at cycle 4+d and NEXT at cycle 5+d. LOAD for the next channel follows at cycle 6+d.
- Cycle cost per channel:
  - Enabled channel: 5+d cycles, where d is the number of WAIT cycles before `enc_done`.
  - Disabled channel: 2 cycles.
  - Timed-out channel: 3+TIMEOUT cycles.
- `busy` goes high the cycle after an `fs` is accepted. It falls in the cycle after `frame_done`.
- Frame budget: the system must guarantee that the sum of per-channel costs is below the `fs` period. Violations show up as `overrun`.

## Test plan

All scenarios use NCH=4, CW=2, TIMEOUT=8.

1. **Reset:** assert `reset` for 2 cycles → all outputs 0, `ch_sel`=0, `busy`=0.
2. **Full frame:** `ch_mask`=4'b1111, `fs` at cycle 0, encoder model returns `enc_done` 2 cycles after each `enc_start` (d=1) → `state_rd`/`enc_start`/`state_wr` for ch0–3 in order, `state_wr` at cycles 5, 11, 17, 23, `frame_done` at cycle 24, `busy` low at 25.
3. **Masked channels:** `ch_mask`=4'b0101, d=1 → exactly 2 `state_wr`, at `ch_sel`=0 and `ch_sel`=2; channels 1 and 3 take 2 cycles each; `frame_done` at cycle 16.
4. **Timeout:** on ch1 the encoder never asserts `enc_done` → after 8 WAIT cycles `timeout_err`=1 and no `state_wr` at ch1; ch2 and ch3 still process; `err_clr` pulse → `timeout_err`=0 next cycle.
5. **Overrun:** second `fs` pulse while `busy`=1, then another exactly on the `frame_done` cycle → `overrun`=1, the current frame is unaffected, the FSM returns to IDLE, and the next `fs` starts a normal frame.
6. **Reset mid-WAIT:** assert `reset` on ch2 during WAIT → IDLE next cycle, `state_wr` never issued for ch2, then a new `fs` restarts from ch0.
